// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Purpose:
//   Receives a byte stream framed as
//     SYNC_BYTE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA[0..LEN-1], CHECKSUM
//   and writes each data byte to consecutive memory locations, starting at
//   the given address. The checksum is the XOR of all data bytes. If it
//   does not match, a sticky error flag is set.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream byte available
//   in_data    upstream byte
//   in_ready   byte accepted when in_valid && in_ready at a rising clk
//   mem_we     memory write enable (registered, high only in WRITE)
//   mem_addr   memory address (registered)
//   mem_wdata  memory write data (registered); drive onto the bus only
//              while mem_we=1
//   busy       a frame is in progress; keeps the CPU off the memory bus
//   done       one-cycle pulse when a frame finishes
//   error      checksum mismatch; sticky until the next accepted SYNC_BYTE
//
// ADDR_WIDTH must lie in 9..16. The 16-bit header address is truncated to
// ADDR_WIDTH bits.
// -----------------------------------------------------------------------------
module mem_loader #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        StIdle,
        StAddrLo,
        StAddrHi,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCheck,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;

    assign accept = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            csum_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = StAddrLo;
                end
            end
            StAddrLo: begin
                if (accept) state_d = StAddrHi;
            end
            StAddrHi: begin
                if (accept) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) state_d = StLenHi;
            end
            StLenHi: begin
                if (accept) begin
                    state_d = ({in_data, count_q[7:0]} == 16'd0) ? StCheck : StData;
                end
            end
            StData: begin
                if (accept) state_d = StWrite;
            end
            StWrite: begin
                // count_q still holds the value before this write's decrement
                state_d = (count_q == 16'd1) ? StCheck : StData;
            end
            StCheck: begin
                if (accept) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state: address, length, checksum, write data, error
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        csum_d  = csum_q;
        wdata_d = wdata_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    csum_d  = 8'h00;
                    error_d = 1'b0;
                end
            end
            StAddrLo: begin
                if (accept) begin
                    addr_d      = '0;
                    addr_d[7:0] = in_data;
                end
            end
            StAddrHi: begin
                // Header address bits above ADDR_WIDTH-1 are dropped
                if (accept) begin
                    addr_d[ADDR_WIDTH-1:8] = in_data[ADDR_WIDTH-9:0];
                end
            end
            StLenLo: begin
                if (accept) count_d[7:0] = in_data;
            end
            StLenHi: begin
                if (accept) count_d[15:8] = in_data;
            end
            StData: begin
                if (accept) begin
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                end
            end
            StWrite: begin
                // Address wraps naturally from all-ones to zero
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 16'd1;
            end
            StCheck: begin
                if (accept && (in_data != csum_q)) begin
                    error_d = 1'b1;
                end
            end
            StFinish: begin
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. in_ready decodes the current state. The strobes are
    // registered from the next state, so they line up with the state they
    // describe without a combinational path to the outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle, StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StCheck: begin
                in_ready = 1'b1;
            end
            StWrite, StFinish: begin
                in_ready = 1'b0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        we_d   = (state_d == StWrite);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFinish);
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader. Expected writes are queued as each data
// byte is sent. They are popped and compared when mem_we is seen at the
// falling edge.
module tb_mem_loader;

    localparam int unsigned AW = 15;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;

    wr_t           sb[$];
    wr_t           exp_wr;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            gap_max = 0;
    logic [7:0]    payload[16];
    logic          prev_we = 1'b0;

    mem_loader #(
        .SYNC_BYTE  (8'hA5),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write monitor: memory captures on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_wr = sb.pop_front();
                    chk("wr_addr", {17'd0, mem_addr}, {17'd0, exp_wr.addr});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, exp_wr.data});
                end
            end
            prev_we = mem_we;
        end
    end

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic rdy;
        waited = 0;
        repeat ($urandom_range(gap_max, 0)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] start, input logic [15:0] n,
                             input logic [7:0] corrupt);
        logic [AW-1:0] a;
        logic [7:0]    cs;
        cs = 8'h00;
        send_byte(8'hA5);
        chk("busy_after_sync", {31'd0, busy}, 32'd1);
        chk("error_clear_at_sync", {31'd0, error}, 32'd0);
        send_byte(start[7:0]);
        send_byte(start[15:8]);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        a = start[AW-1:0];
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back('{addr: a, data: payload[i]});
            cs = cs ^ payload[i];
            send_byte(payload[i]);
            a = a + 1'b1;
        end
        send_byte(cs ^ corrupt);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_finish", {31'd0, busy}, 32'd1);
        chk("error_after_check", {31'd0, error}, {31'd0, (corrupt != 8'h00)});
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Address 0x8000 truncates to 0x0000
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        run_frame(16'h8000, 16'd3, 8'h00);

        // Address wrap 7FFF -> 0000, checksum DD
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
        run_frame(16'h7FFE, 16'd3, 8'h00);

        // Junk bytes while idle, then a zero-length frame
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk_not_busy", {31'd0, busy}, 32'd0);
        run_frame(16'h0000, 16'd0, 8'h00);

        // 16-byte frame gap-free, then with random in_valid gaps
        for (int i = 0; i < 16; i++) payload[i] = 8'(i * 37 + 5);
        payload[3] = 8'hA5;  // sync value inside data is plain content
        gap_max = 0;
        run_frame(16'h0100, 16'd16, 8'h00);
        gap_max = 3;
        run_frame(16'h0100, 16'd16, 8'h00);
        gap_max = 0;

        // Checksum mismatch: error sticks through idle
        payload[0] = 8'h5A;
        run_frame(16'h1000, 16'd1, 8'h5A);
        send_byte(8'h00);
        chk("error_sticky_junk", {31'd0, error}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("error_sticky_idle", {31'd0, error}, 32'd1);

        // Reset during the second WRITE of a 4-byte frame
        send_byte(8'hA5);
        chk("error_clear_next_sync", {31'd0, error}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'h00);
        sb.push_back('{addr: 15'h2000, data: 8'h01});
        send_byte(8'h01);
        send_byte(8'h02);
        chk("second_write_active", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("arst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("arst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_one_write", sb.size(), 32'd0);
        send_byte(8'h03);
        chk("arst_needs_sync", {31'd0, busy}, 32'd0);
        payload[0] = 8'h77;
        run_frame(16'h0005, 16'd1, 8'h00);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
